mips_output_port: RTL and testbench

- CPU-facing output port: the transmit-direction counterpart of the MIPS input latch.
- The MIPS core writes bytes with a one-cycle write strobe. The block buffers them in a small FIFO and presents them to an external sink over a valid/ready handshake.
- It reports full/empty/occupancy and a sticky overflow flag back to the core for polling.
- It sits on the core's memory-mapped I/O bus alongside the input port.

---
 rtl/mips_output_port.sv | 103 ++++++++++
 tb/tb_mips_output_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_output_port.sv
// CPU-facing transmit port. The CPU pushes bytes into a small FIFO, and an
// external sink drains them over a valid/ready handshake.
module mips_output_port #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              port_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] last_wr,
  output logic              ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] last_wr_q, last_wr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              push, pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = port_en & ~empty;
  // The hold register keeps the last shown byte visible once the FIFO drains.
  assign out_data  = empty ? hold_q : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign last_wr   = last_wr_q;
  assign ovf       = ovf_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    push      = wr_en & ~full;
    pop       = out_valid & out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_wr_d = last_wr_q;
    ovf_d     = ovf_q;
    hold_d    = out_data;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      last_wr_d = wr_data;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh overflow wins over a simultaneous clear.
    if (wr_en & full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      last_wr_q <= '0;
      hold_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      last_wr_q <= last_wr_d;
      hold_q    <= hold_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_output_port.sv
// Directed bench for mips_output_port. A queue-based model is compared with
// the DUT on every negedge, and literal checks pin key points of each scenario.
module tb_mips_output_port;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              port_en = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] last_wr;
  logic              ovf;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mips_output_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .port_en(port_en), .clr_ovf(clr_ovf), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .full(full),
    .empty(empty), .count(count), .last_wr(last_wr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus the status registers.
  logic [DATA_W-1:0] m_q [$];
  bit                m_ovf = 1'b0;
  logic [DATA_W-1:0] m_last_wr = '0;
  logic [DATA_W-1:0] m_last_out = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf      = 1'b0;
      m_last_wr  = '0;
      m_last_out = '0;
    end else begin
      bit do_push, do_pop, do_ovf;
      do_push = wr_en && (m_q.size() < DEPTH);
      do_ovf  = wr_en && (m_q.size() == DEPTH);
      do_pop  = port_en && out_ready && (m_q.size() > 0);
      if (m_q.size() > 0) m_last_out = m_q[0];
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(wr_data);
        m_last_wr = wr_data;
      end
      if (do_ovf) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = m_q.size();
      check("m_count",     32'(count),     32'(sz));
      check("m_empty",     32'(empty),     32'(sz == 0));
      check("m_full",      32'(full),      32'(sz == DEPTH));
      check("m_out_valid", 32'(out_valid), 32'(port_en && sz > 0));
      check("m_out_data",  32'(out_data),  32'((sz > 0) ? m_q[0] : m_last_out));
      check("m_last_wr",   32'(last_wr),   32'(m_last_wr));
      check("m_ovf",       32'(ovf),       32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [DATA_W-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] fill [5];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // 1. reset then idle
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0; port_en = 1'b1; out_ready = 1'b1;
    repeat (3) cyc();
    check("idle_count", 32'(count), 0);
    check("idle_empty", 32'(empty), 1);
    check("idle_valid", 32'(out_valid), 0);
    check("idle_ovf",   32'(ovf), 0);
    check("idle_lastwr", 32'(last_wr), 0);

    // 2. single byte
    write_byte(8'hA5);
    check("single_valid", 32'(out_valid), 1);
    check("single_data",  32'(out_data), 'hA5);
    check("single_lastwr", 32'(last_wr), 'hA5);
    check("single_count", 32'(count), 1);
    cyc();
    check("single_drained_valid", 32'(out_valid), 0);
    check("single_drained_count", 32'(count), 0);
    check("single_hold_data", 32'(out_data), 'hA5);

    // 3. fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(fill[i]);
    check("fill_full",   32'(full), 1);
    check("fill_count",  32'(count), 4);
    check("fill_ovf",    32'(ovf), 1);
    check("fill_lastwr", 32'(last_wr), 'h44);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(out_data), 32'(fill[i]));
      cyc();
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_ovf_sticky", 32'(ovf), 1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf), 0);

    // 4. backpressure and port_en
    out_ready = 1'b0;
    write_byte(8'h01);
    write_byte(8'h02);
    cyc();
    check("bp_hold_data", 32'(out_data), 'h01);
    check("bp_count", 32'(count), 2);
    port_en = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    check("pen_valid", 32'(out_valid), 0);
    check("pen_count", 32'(count), 2);
    write_byte(8'h03);
    check("pen_write_count", 32'(count), 3);
    port_en = 1'b1;
    for (int i = 0; i < 10 && count != 0; i++) begin
      out_ready = i[0];
      cyc();
    end
    check("bp_drained", 32'(empty), 1);

    // 5. wrap-around with simultaneous push/pop
    out_ready = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(i);
      cyc();
      check("stream_count", 32'(count), 1);
      check("stream_data", 32'(out_data), 32'(i));
    end
    wr_en = 1'b0;
    cyc();
    check("stream_end_count", 32'(count), 0);
    check("stream_ovf", 32'(ovf), 0);

    // 6. mid-stream reset during an active handshake
    out_ready = 1'b0;
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_lastwr", 32'(last_wr), 0);
    out_ready = 1'b0;
    write_byte(8'hD1);
    write_byte(8'hD2);
    check("post_rst_data", 32'(out_data), 'hD1);
    check("post_rst_count", 32'(count), 2);
    out_ready = 1'b1;
    cyc();
    check("post_rst_second", 32'(out_data), 'hD2);
    cyc();
    check("post_rst_empty", 32'(empty), 1);
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
